// File: rtl/relu_sched_if.sv
// Requester and result-stream handshake bundle for relu_sched.
// The DUT uses the slave modport; the requesters/consumer side uses master.
interface relu_sched_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 12
);
    logic                  req0_valid;
    logic [LANES*DW-1:0]   req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [LANES*DW-1:0]   req1_data;
    logic                  req1_ready;
    logic                  out_valid;
    logic [LANES*DW-1:0]   out_data;
    logic                  out_src;
    logic                  out_ready;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/relu_sched.sv
// Round-robin scheduler feeding two MAC requesters through one shared 4-lane ReLu stage,
// returning tagged results via a 2-entry FIFO. Define RELU_SCHED_STATS_EN to add zero_cnt.
module relu_sched #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [CNT_W-1:0]     cfg_num_vec,
    relu_sched_if.slave          bus,
    output logic [LANES*DW-1:0]  relu_y,
    input  logic [LANES*DW-1:0]  relu_z,
    output logic                 busy,
    output logic                 done
`ifdef RELU_SCHED_STATS_EN
    ,
    output logic [CNT_W+2:0]     zero_cnt
`endif
);
    localparam int unsigned VW = LANES * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   num_vec;
    logic [CNT_W-1:0]   issued;
    logic               rr_ptr;
    logic               inflight;
    logic               src_q;
    logic [VW-1:0]      fifo_data [2];
    logic               fifo_src  [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         fifo_count;
    logic               pop;
    logic [2:0]         occ;
    logic               can_issue;
    logic               grant0;
    logic               grant1;

    // Slots committed after this cycle: FIFO plus in-flight minus what leaves now
    assign pop = bus.out_valid & bus.out_ready;
    assign occ = 3'(fifo_count) + 3'(inflight) - 3'(pop);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = (fifo_count != 2'd0);
    assign bus.out_data   = fifo_data[rd_ptr];
    assign bus.out_src    = fifo_src[rd_ptr];
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, issue decision and grant steering
    always_comb begin
        state_nx  = state;
        can_issue = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        relu_y    = '0;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nx = (cfg_num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                can_issue = (issued < num_vec) && (occ < 3'd2);
                if (issued == num_vec) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && (fifo_count == 2'd0)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (can_issue) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        if (grant1) begin
            relu_y = bus.req1_data;
        end else if (grant0) begin
            relu_y = bus.req0_data;
        end
    end

    // Layer counters, arbitration pointer, in-flight slot and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            num_vec    <= '0;
            issued     <= '0;
            rr_ptr     <= 1'b0;
            inflight   <= 1'b0;
            src_q      <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if ((state == S_IDLE) && cfg_start) begin
                num_vec <= cfg_num_vec;
                issued  <= '0;
            end else if (grant0 | grant1) begin
                issued <= issued + CNT_W'(1);
            end
            if (grant0 | grant1) begin
                rr_ptr <= ~grant1;
            end
            inflight <= grant0 | grant1;
            src_q    <= grant1;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(inflight) - 2'(pop);
        end
    end

    // Result storage; when full, a simultaneous pop frees the slot being written
    always_ff @(posedge clk) begin
        if (inflight && !rst) begin
            fifo_data[wr_ptr] <= relu_z;
            fifo_src[wr_ptr]  <= src_q;
        end
    end

`ifdef RELU_SCHED_STATS_EN
    localparam int unsigned ZW  = CNT_W + 3;
    localparam int unsigned ZSW = ZW + 1;
    localparam int unsigned ZLW = $clog2(LANES + 1);

    logic [ZLW-1:0] lane_zeros;
    logic [ZSW-1:0] zsum;

    always_comb begin
        lane_zeros = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (relu_z[k*DW +: DW] == '0) begin
                lane_zeros = lane_zeros + ZLW'(1);
            end
        end
        zsum = {1'b0, zero_cnt} + ZSW'(lane_zeros);
    end

    // Zero-lane count of pushed vectors, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt <= '0;
        end else if ((state == S_IDLE) && cfg_start) begin
            zero_cnt <= '0;
        end else if (inflight) begin
            zero_cnt <= zsum[ZW] ? '1 : zsum[ZW-1:0];
        end
    end
`else
    // statistics counter not built
`endif

endmodule
